// File: rtl/seq_divider_param.sv
// Multi-cycle restoring divider, WIDTH bits, STEPS_PER_CYCLE quotient bits per clock.
// Define SIGNED_DIV_EN to add the i_signed_op port and two's-complement operation.
module seq_divider_param #(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
`ifdef SIGNED_DIV_EN
    input  logic             i_signed_op,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int N  = WIDTH / STEPS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_q_out;
    logic [WIDTH-1:0] r_r_out;
    logic             r_zero;
    logic             r_dbz;

    logic             w_accept;
    logic             w_last;
    logic             w_dvs_zero;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH:0]   w_rs;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_accept   = i_start && (r_state != S_RUN);
    assign w_last     = (r_cnt == LAST);
    assign w_dvs_zero = (i_divisor == '0);

`ifdef SIGNED_DIV_EN
    logic w_neg_a;
    logic w_neg_b;
    logic r_neg_q;
    logic r_neg_r;

    assign w_neg_a   = i_signed_op & i_dividend[WIDTH-1];
    assign w_neg_b   = i_signed_op & i_divisor[WIDTH-1];
    assign w_dvd_mag = w_neg_a ? (~i_dividend + WIDTH'(1)) : i_dividend;
    assign w_dvs_mag = w_neg_b ? (~i_divisor + WIDTH'(1)) : i_divisor;
    // Truncating division: quotient sign = sign xor, remainder follows dividend
    assign w_q_fix   = r_neg_q ? (~w_quo_nx + WIDTH'(1)) : w_quo_nx;
    assign w_r_fix   = r_neg_r ? (~w_rem_nx + WIDTH'(1)) : w_rem_nx;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= ~w_dvs_zero & (w_neg_a ^ w_neg_b);
            r_neg_r <= ~w_dvs_zero & w_neg_a;
        end
    end
`else
    assign w_dvd_mag = i_dividend;
    assign w_dvs_mag = i_divisor;
    assign w_q_fix   = w_quo_nx;
    assign w_r_fix   = w_rem_nx;
`endif

    // r_quo shifts dividend bits out of the MSB and quotient bits in at the LSB
    always_comb begin
        w_quo_nx = r_quo;
        w_rem_nx = r_rem;
        w_rs     = '0;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            w_rs = {w_rem_nx, w_quo_nx[WIDTH-1]};
            if (w_rs >= {1'b0, r_dvs}) begin
                w_rem_nx = w_rs[WIDTH-1:0] - r_dvs;
                w_quo_nx = {w_quo_nx[WIDTH-2:0], 1'b1};
            end else begin
                w_rem_nx = w_rs[WIDTH-1:0];
                w_quo_nx = {w_quo_nx[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: if (i_start) w_state_nx = S_RUN;
            S_RUN:  if (r_zero || w_last) w_state_nx = S_DONE;
            S_DONE: w_state_nx = i_start ? S_RUN : S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_q_out <= '0;
            r_r_out <= '0;
            r_zero  <= 1'b0;
            r_dbz   <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_dvs  <= w_dvs_mag;
            r_zero <= w_dvs_zero;
            r_dbz  <= w_dvs_zero;
            // Zero divisor keeps the raw dividend for the remainder output
            r_quo  <= w_dvs_zero ? i_dividend : w_dvd_mag;
        end else if (r_state == S_RUN) begin
            if (r_zero) begin
                r_q_out <= '1;
                r_r_out <= r_quo;
            end else begin
                r_quo <= w_quo_nx;
                r_rem <= w_rem_nx;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_q_out <= w_q_fix;
                    r_r_out <= w_r_fix;
                end
            end
        end
    end

    assign o_busy        = (r_state == S_RUN);
    assign o_done        = (r_state == S_DONE);
    assign o_quotient    = r_q_out;
    assign o_remainder   = r_r_out;
    assign o_div_by_zero = r_dbz;

endmodule
